// File: rtl/alu_seq_ctrl_if.sv
// Bundle of the instruction-fetch, register-file and alu_ctrl signals around alu_seq_ctrl.
// master = sequencer side, slave = memory / register file / alu_ctrl side.
interface alu_seq_ctrl_if;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid;
  logic [7:0] imem_data;
  logic [1:0] rf_raddr1;
  logic [1:0] rf_raddr2;
  logic [7:0] rf_rdata1;
  logic [7:0] rf_rdata2;
  logic [2:0] alu_op;
  logic [7:0] alu_data1;
  logic [7:0] alu_data2;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       halt;

  modport master (
    output imem_req, imem_addr, rf_raddr1, rf_raddr2,
           alu_op, alu_data1, alu_data2, rf_we, rf_waddr, rf_wdata, halt,
    input  imem_valid, imem_data, rf_rdata1, rf_rdata2, alu_result, alu_zero
  );

  modport slave (
    input  imem_req, imem_addr, rf_raddr1, rf_raddr2,
           alu_op, alu_data1, alu_data2, rf_we, rf_waddr, rf_wdata, halt,
    output imem_valid, imem_data, rf_rdata1, rf_rdata2, alu_result, alu_zero
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer of the 8-bit core, feeding alu_ctrl.
// Optional SEQ_SINGLE_STEP_EN adds a 'step' input that gates each instruction fetch.
//
// state   | meaning
// FETCH   | request opcode byte at pc, wait for imem_valid
// DECODE  | latch register operands for alu_ctrl, pick next state
// FETCH2  | request second byte (beq offset / li immediate)
// EXEC    | alu_op = opcode for one cycle
// WB      | write back result/immediate, or resolve beq
// HALT    | stopped until reset
module alu_seq_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [2:0] IDLE_OP  = 3'b111
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic step,
`endif
  alu_seq_ctrl_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_FETCH2 = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_LI   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  logic [2:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] data1_q, data1_d;
  logic [7:0] data2_q, data2_d;
  logic       imem_req_q, imem_req_d;
  logic       fetch_hit;
  logic       fetch_allow;
  logic [2:0] op;
  logic       ir_unused;

  assign op        = ir_q[7:5];
  assign ir_unused = ir_q[0];
  // Valid only counts while our own registered request is up.
  assign fetch_hit = imem_req_q && bus.imem_valid;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    operand_d = operand_q;
    data1_d   = data1_q;
    data2_d   = data2_q;
    case (state_q)
      S_FETCH: begin
        if (fetch_hit) begin
          ir_d    = bus.imem_data;
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        data1_d = bus.rf_rdata1;
        data2_d = bus.rf_rdata2;
        if (op == OP_HALT)                     state_d = S_HALT;
        else if (op == OP_BEQ || op == OP_LI)  state_d = S_FETCH2;
        else                                   state_d = S_EXEC;
      end
      S_FETCH2: begin
        if (fetch_hit) begin
          operand_d = bus.imem_data;
          pc_d      = pc_q + 8'd1;
          state_d   = (op == OP_BEQ) ? S_EXEC : S_WB;
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        if (op == OP_BEQ && bus.alu_zero) pc_d = pc_q + operand_q;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

`ifdef SEQ_SINGLE_STEP_EN
  logic step_ok_q, step_ok_d;

  // One step sample arms a single opcode fetch; leaving FETCH disarms it.
  always_comb begin
    step_ok_d = (state_d == S_FETCH) && (step_ok_q || (state_q == S_FETCH && step));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_ok_q <= 1'b0;
    else        step_ok_q <= step_ok_d;
  end

  assign fetch_allow = step_ok_d;
`else
  assign fetch_allow = 1'b1;
`endif

  always_comb begin
    imem_req_d = (state_d == S_FETCH2) || ((state_d == S_FETCH) && fetch_allow);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 8'h00;
      operand_q  <= 8'h00;
      data1_q    <= 8'h00;
      data2_q    <= 8'h00;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      operand_q  <= operand_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      imem_req_q <= imem_req_d;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.rf_raddr1 = ir_q[4:3];
  assign bus.rf_raddr2 = ir_q[2:1];
  assign bus.rf_waddr  = ir_q[4:3];
  assign bus.alu_data1 = data1_q;
  assign bus.alu_data2 = data2_q;
  assign bus.alu_op    = (state_q == S_EXEC) ? op : IDLE_OP;
  // Write strobe decodes straight from state so an async reset kills it at once.
  assign bus.rf_we     = (state_q == S_WB) && (op != OP_BEQ);
  assign bus.rf_wdata  = (state_q != S_WB) ? 8'h00 :
                         (op == OP_LI)     ? operand_q :
                         (op == OP_BEQ)    ? 8'h00 : bus.alu_result;
  assign bus.halt      = (state_q == S_HALT);

endmodule
